// File: rtl/i2s_playback_if.sv
// Byte handshake between the playback FIFO read port and the I2S transmitter.
//   byte_i       : byte offered by the FIFO
//   byte_valid_i : byte_i holds a valid byte
//   byte_ready_o : transmitter takes byte_i on this cycle
// The master modport is the FIFO side. The slave modport is the transmitter.
interface i2s_playback_if;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_ready_o;

  modport master (output byte_i, output byte_valid_i, input byte_ready_o);
  modport slave  (input byte_i, input byte_valid_i, output byte_ready_o);
endinterface

// File: rtl/i2s_playback.sv
// I2S master transmitter for the playback path.
// Bytes come in over the FIFO handshake and are paired low byte first into
// 16-bit samples. Sync-marker words are dropped. Each sample is sent MSB-first
// in both slots for REPEAT_FACTOR frames. Bit clock and word select are
// derived from clk.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   fifo            : byte handshake (slave side)
//   i2s_clk         : bit clock
//   i2s_ws          : word select (0 = left, 1 = right)
//   i2s_sd          : serial data
//   underrun_count  : saturating count of needed-sample frames with no sample
//   sync_count      : wrapping count of dropped sync words
//
// Assembler FSM
//   state   | meaning
//   WAIT_LO | ready, waiting for the low byte
//   WAIT_HI | ready, waiting for the high byte
//   HOLD    | pending sample full, waiting for the frame loader
module i2s_playback #(
  parameter int          CLK_FREQ      = 100_000_000,
  parameter int          TARGET_FREQ   = 1_500_000,
  parameter int          SAMPLE_WIDTH  = 16,
  parameter logic [15:0] SYNC_WORD     = 16'hAAFF,
  parameter int          REPEAT_FACTOR = 2,
  parameter int          SIZE_COUNT    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  i2s_playback_if.slave         fifo,
  output logic                  i2s_clk,
  output logic                  i2s_ws,
  output logic                  i2s_sd,
  output logic [SIZE_COUNT-1:0] underrun_count,
  output logic [SIZE_COUNT-1:0] sync_count
);

  localparam int CLK_DIV = CLK_FREQ / (2 * TARGET_FREQ);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int REP_W   = (REPEAT_FACTOR > 1) ? $clog2(REPEAT_FACTOR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FACTOR - 1);

  typedef enum logic [1:0] {
    WAIT_LO = 2'd0,
    WAIT_HI = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              lo_q, lo_d;
  logic [SAMPLE_WIDTH-1:0] pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [SAMPLE_WIDTH-1:0] frame_q, frame_d;
  logic                    ready_q, ready_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    clk_q, clk_d;
  logic [5:0]              bit_q, bit_d;
  logic [REP_W-1:0]        rep_q, rep_d;
  logic                    ws_q, ws_d;
  logic                    sd_q, sd_d;
  logic [SIZE_COUNT-1:0]   underrun_q, underrun_d;
  logic [SIZE_COUNT-1:0]   sync_q, sync_d;

  logic                    wrap;
  logic                    fall_strobe;
  logic                    frame_end;
  logic                    consume;
  logic                    accept;
  logic [15:0]             word;
  logic [4:0]              slot;

  always_comb begin
    state_d         = state_q;
    lo_d            = lo_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    frame_d         = frame_q;
    div_d           = div_q;
    clk_d           = clk_q;
    bit_d           = bit_q;
    rep_d           = rep_q;
    ws_d            = ws_q;
    sd_d            = sd_q;
    underrun_d      = underrun_q;
    sync_d          = sync_q;
    consume         = 1'b0;
    slot            = 5'd0;

    // Bit-clock divider
    wrap        = (div_q == DIV_LAST);
    fall_strobe = wrap & clk_q;
    if (wrap) begin
      div_d = '0;
      clk_d = ~clk_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    // Frame loader, acting on the fall strobe that starts a new frame
    frame_end = fall_strobe && (bit_q == 6'd63);
    if (frame_end) begin
      rep_d = (rep_q == REP_LAST) ? '0 : rep_q + 1'b1;
      if (rep_q == '0) begin
        if (pending_valid_q) begin
          frame_d         = pending_q;
          pending_valid_d = 1'b0;
          consume         = 1'b1;
        end else begin
          frame_d = '0;
          if (underrun_q != '1) underrun_d = underrun_q + 1'b1;
        end
      end
    end

    // Byte assembler
    accept = fifo.byte_valid_i & ready_q;
    word   = {fifo.byte_i, lo_q};
    case (state_q)
      WAIT_LO: begin
        if (accept) begin
          lo_d    = fifo.byte_i;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (accept) begin
          if (word == SYNC_WORD) begin
            sync_d  = sync_q + 1'b1;
            state_d = WAIT_LO;
          end else begin
            pending_d       = word;
            pending_valid_d = 1'b1;
            state_d         = HOLD;
          end
        end
      end
      HOLD: begin
        if (consume) state_d = WAIT_LO;
      end
      default: state_d = WAIT_LO;
    endcase
    ready_d = (state_d != HOLD);

    // Serial outputs are computed from the next bit position and next frame
    // sample so they are registered together with the falling bit clock.
    if (fall_strobe) begin
      bit_d = bit_q + 1'b1;
      slot  = bit_d[4:0];
      ws_d  = (bit_d >= 6'd31) && (bit_d != 6'd63);
      sd_d  = ~slot[4] & frame_d[~slot[3:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= WAIT_LO;
      lo_q            <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      frame_q         <= '0;
      ready_q         <= 1'b0;
      div_q           <= '0;
      clk_q           <= 1'b0;
      bit_q           <= 6'd63;
      rep_q           <= '0;
      ws_q            <= 1'b0;
      sd_q            <= 1'b0;
      underrun_q      <= '0;
      sync_q          <= '0;
    end else begin
      state_q         <= state_d;
      lo_q            <= lo_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      frame_q         <= frame_d;
      ready_q         <= ready_d;
      div_q           <= div_d;
      clk_q           <= clk_d;
      bit_q           <= bit_d;
      rep_q           <= rep_d;
      ws_q            <= ws_d;
      sd_q            <= sd_d;
      underrun_q      <= underrun_d;
      sync_q          <= sync_d;
    end
  end

  assign fifo.byte_ready_o = ready_q;
  assign i2s_clk           = clk_q;
  assign i2s_ws            = ws_q;
  assign i2s_sd            = sd_q;
  assign underrun_count    = underrun_q;
  assign sync_count        = sync_q;

endmodule

// File: tb/tb_i2s_playback.sv
// Testbench for i2s_playback. A small bit clock (CLK_DIV = 2) keeps the long
// underrun scenario short. A monitor decodes the I2S stream into frames, and
// each scenario compares those frames with a sample-level model.
module tb_i2s_playback;
  localparam int CLK_FREQ = 4_000_000;
  localparam int TARGET_FREQ = 1_000_000;
  localparam int DIV = CLK_FREQ / (2 * TARGET_FREQ);
  localparam int R = 2;
  localparam logic [15:0] SYNC = 16'hAAFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i2s_clk, i2s_ws, i2s_sd;
  logic [5:0] und, syn;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  i2s_playback_if bus();

  i2s_playback #(
    .CLK_FREQ(CLK_FREQ), .TARGET_FREQ(TARGET_FREQ), .SAMPLE_WIDTH(16),
    .SYNC_WORD(SYNC), .REPEAT_FACTOR(R), .SIZE_COUNT(6)
  ) dut (
    .clk(clk), .rst(rst), .fifo(bus),
    .i2s_clk(i2s_clk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .underrun_count(und), .sync_count(syn)
  );

  // Monitor: decode frames from the bit clock rises
  int rst_cnt = 0;
  always @(posedge clk) if (rst) rst_cnt++;

  int mon_rst_seen = 0;
  int rise_n, period_cnt, last_period, ws_err, mb;
  logic prev_clk;
  logic fbits[64];
  logic [15:0] ml, mr;
  logic mpad;
  logic [15:0] fl[$], fr[$];
  logic fpad[$];
  int fws[$];
  logic [5:0] fund[$];

  always @(negedge clk) begin
    if (rst || (mon_rst_seen != rst_cnt)) begin
      mon_rst_seen = rst_cnt;
      rise_n = 0; period_cnt = 0; last_period = 0; ws_err = 0; prev_clk = 1'b0;
      fl.delete(); fr.delete(); fpad.delete(); fws.delete(); fund.delete();
    end else begin
      period_cnt++;
      if (i2s_clk && !prev_clk) begin
        mb = (rise_n == 0) ? 63 : (rise_n - 1) % 64;
        if (rise_n > 0) last_period = period_cnt;
        period_cnt = 0;
        if (i2s_ws !== ((mb >= 31) && (mb <= 62))) ws_err++;
        fbits[mb] = i2s_sd;
        if (mb == 63 && rise_n > 0) begin
          mpad = 1'b0;
          for (int i = 0; i < 16; i++) begin
            ml[15-i] = fbits[i];
            mr[15-i] = fbits[32+i];
            mpad = mpad | fbits[16+i] | fbits[48+i];
          end
          fl.push_back(ml); fr.push_back(mr); fpad.push_back(mpad);
          fws.push_back(ws_err); fund.push_back(und);
          ws_err = 0;
        end
        rise_n++;
      end
      prev_clk = i2s_clk;
    end
  end

  // Sample-level model: samples become available from boundary model_b0 on,
  // one per needed-sample boundary (every R frames), silence once exhausted.
  logic [15:0] model_s[$];
  int model_b0;

  function automatic logic [15:0] exp_sample(int f);
    int k;
    k = f / R;
    if (k < model_b0 || (k - model_b0) >= model_s.size()) return 16'h0000;
    return model_s[k - model_b0];
  endfunction

  function automatic logic [5:0] exp_und(int loads);
    int nb, c;
    nb = (loads + R - 1) / R;
    c = 0;
    for (int k = 0; k < nb; k++)
      if (k < model_b0 || (k - model_b0) >= model_s.size()) c++;
    if (c > 63) c = 63;
    return 6'(c);
  endfunction

  // Stimulus helpers (all called at a falling clk edge)
  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1;
    bus.byte_valid_i = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(logic [7:0] b);
    int t;
    bus.byte_i = b;
    bus.byte_valid_i = 1'b1;
    t = 0;
    while (!bus.byte_ready_o && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      total++; bad++;
      $display("FAIL push_timeout: byte %h got ready=0 want ready=1", b);
    end
    @(posedge clk);
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic wait_frames(int n);
    int t;
    t = 0;
    while (fl.size() < n && t < n * 64 * 2 * DIV + 2000) begin
      @(negedge clk);
      t++;
    end
    if (fl.size() < n) begin
      total++; bad++;
      $display("FAIL frame_timeout: got %0d frames want %0d", fl.size(), n);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.byte_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if ({bus.byte_ready_o, i2s_clk, i2s_ws, i2s_sd, und, syn} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {bus.byte_ready_o, i2s_clk, i2s_ws, i2s_sd, und, syn});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.byte_ready_o !== 1'b1 || i2s_clk !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_reset: got ready=%b clk=%b want 1 0", bus.byte_ready_o, i2s_clk);
    end
    model_s.delete(); model_b0 = 0;
    wait_frames(2);
    total++;
    if (last_period !== 2 * DIV) begin
      bad++;
      $display("FAIL bclk_period: got %0d want %0d", last_period, 2 * DIV);
    end
    for (int f = 0; f < fl.size(); f++) begin
      total++;
      if ({fl[f], fr[f], fpad[f]} !== 33'h0 || fund[f] !== exp_und(f + 1)) begin
        bad++;
        $display("FAIL reset_idle f%0d: got l=%h r=%h pad=%b und=%0d want 0 0 0 %0d",
                 f, fl[f], fr[f], fpad[f], fund[f], exp_und(f + 1));
      end
    end
  endtask

  task automatic test_basic();
    do_reset(5);
    push(8'h34); push(8'h12);
    model_s.delete(); model_s.push_back(16'h1234); model_b0 = 0;
    wait_frames(4);
    for (int f = 0; f < fl.size(); f++) begin
      total++;
      if (fl[f] !== exp_sample(f) || fr[f] !== exp_sample(f) || fpad[f] !== 1'b0 ||
          fws[f] != 0 || fund[f] !== exp_und(f + 1)) begin
        bad++;
        $display("FAIL basic f%0d: got l=%h r=%h pad=%b wserr=%0d und=%0d want %h %h 0 0 %0d",
                 f, fl[f], fr[f], fpad[f], fws[f], fund[f], exp_sample(f), exp_sample(f),
                 exp_und(f + 1));
      end
    end
  endtask

  task automatic test_sync();
    do_reset(5);
    repeat (10) @(negedge clk);
    push(8'hFF); push(8'hAA); push(8'h78); push(8'h56);
    model_s.delete(); model_s.push_back(16'h5678); model_b0 = 1;
    wait_frames(6);
    total++;
    if (syn !== 6'd1) begin
      bad++;
      $display("FAIL sync_count: got %0d want 1", syn);
    end
    for (int f = 0; f < fl.size(); f++) begin
      total++;
      if (fl[f] !== exp_sample(f) || fr[f] !== exp_sample(f) || fl[f] === SYNC ||
          fund[f] !== exp_und(f + 1)) begin
        bad++;
        $display("FAIL sync_drop f%0d: got l=%h r=%h und=%0d want %h %h %0d",
                 f, fl[f], fr[f], fund[f], exp_sample(f), exp_sample(f), exp_und(f + 1));
      end
    end
  endtask

  task automatic test_repeat_backpressure();
    do_reset(5);
    push(8'h01); push(8'h00); push(8'h00); push(8'h80);
    @(negedge clk);
    total++;
    if (bus.byte_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_ready: got %b want 0", bus.byte_ready_o);
    end
    repeat (100) @(negedge clk);
    total++;
    if (bus.byte_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_ready_late: got %b want 0", bus.byte_ready_o);
    end
    model_s.delete(); model_s.push_back(16'h0001); model_s.push_back(16'h8000);
    model_b0 = 0;
    wait_frames(6);
    for (int f = 0; f < fl.size(); f++) begin
      total++;
      if (fl[f] !== exp_sample(f) || fr[f] !== exp_sample(f) || fund[f] !== exp_und(f + 1)) begin
        bad++;
        $display("FAIL repeat f%0d: got l=%h r=%h und=%0d want %h %h %0d",
                 f, fl[f], fr[f], fund[f], exp_sample(f), exp_sample(f), exp_und(f + 1));
      end
    end
  endtask

  task automatic test_underrun_saturation();
    do_reset(5);
    model_s.delete(); model_b0 = 0;
    wait_frames(141);
    for (int f = 0; f < fl.size(); f++) begin
      total++;
      if ({fl[f], fr[f], fpad[f]} !== 33'h0 || fund[f] !== exp_und(f + 1)) begin
        bad++;
        $display("FAIL underrun f%0d: got l=%h r=%h und=%0d want 0 0 %0d",
                 f, fl[f], fr[f], fund[f], exp_und(f + 1));
      end
    end
    total++;
    if (und !== 6'd63) begin
      bad++;
      $display("FAIL underrun_sat: got %0d want 63", und);
    end
  endtask

  task automatic test_reset_mid_pair();
    do_reset(5);
    repeat (10) @(negedge clk);
    push(8'h11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(8'h22); push(8'h33);
    model_s.delete(); model_s.push_back(16'h3322); model_b0 = 0;
    wait_frames(4);
    for (int f = 0; f < fl.size(); f++) begin
      total++;
      if (fl[f] !== exp_sample(f) || fr[f] !== exp_sample(f) || fund[f] !== exp_und(f + 1)) begin
        bad++;
        $display("FAIL reset_mid f%0d: got l=%h r=%h und=%0d want %h %h %0d",
                 f, fl[f], fr[f], fund[f], exp_sample(f), exp_sample(f), exp_und(f + 1));
      end
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] w;
    int nsync;
    do_reset(5);
    repeat (10) @(negedge clk);
    model_s.delete(); model_b0 = 1; nsync = 0;
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        nsync++;
        push(SYNC[7:0]); push(SYNC[15:8]);
      end
      w = 16'($urandom_range(0, 65535));
      if (w == SYNC) w = 16'h1357;
      model_s.push_back(w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(w[7:0]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(w[15:8]);
    end
    wait_frames(16);
    total++;
    if (syn !== 6'(nsync)) begin
      bad++;
      $display("FAIL random_sync: got %0d want %0d", syn, nsync);
    end
    for (int f = 0; f < fl.size(); f++) begin
      total++;
      if (fl[f] !== exp_sample(f) || fr[f] !== exp_sample(f) || fpad[f] !== 1'b0 ||
          fws[f] != 0 || fund[f] !== exp_und(f + 1)) begin
        bad++;
        $display("FAIL random f%0d: got l=%h r=%h pad=%b wserr=%0d und=%0d want %h %h 0 0 %0d",
                 f, fl[f], fr[f], fpad[f], fws[f], fund[f], exp_sample(f), exp_sample(f),
                 exp_und(f + 1));
      end
    end
  endtask

  initial begin
    bus.byte_i = 8'h00;
    bus.byte_valid_i = 1'b0;
    test_reset();
    test_basic();
    test_sync();
    test_repeat_backpressure();
    test_underrun_saturation();
    test_reset_mid_pair();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
